// File: rtl/nios_mul_seq.sv
// rtl/nios_mul_seq.sv - request sequencer feeding the Nios 32x32 multiplier cell
//
// Accepts one multiply request at a time and drives the cell operands.
// MUL (and reserved op 11) issues one full-width pair and returns the low word.
// MULXUU/MULXSS issue four 16x16 partial products, accumulate them into a
// 64-bit sum and return the high word.
//
// Optional feature macro: NIOS_MUL_SIGNED_HI_EN
//   defined   : op 10 returns the signed high word (correction applied on RESP entry)
//   undefined : op 10 behaves as op 01 (unsigned high word)
//
// Parameters:
//   CELL_LATENCY       cycles from operands on A_mul_src* to A_mul_cell_result (1..4)
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req_valid/ready    request handshake; req_op, req_src1, req_src2 request payload
//   A_mul_src1/2       operands to the cell, 0 when nothing is issued
//   A_mul_cell_result  product from the cell
//   rsp_valid/ready    response handshake; rsp_result response word
//   busy               high whenever the sequencer is not idle
module nios_mul_seq #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [31:0] A_mul_src1,
  output logic [31:0] A_mul_src2,
  input  logic [31:0] A_mul_cell_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [1:0]  cnt_q;
  logic [63:0] acc_q, acc_d;
  logic [31:0] res_q;
  logic [31:0] hi_word;
  logic [31:0] src1_d, src2_d;

  // Tag = {valid, partial-product index}; the oldest entry lines up with
  // the cell result that belongs to it.
  logic [2:0]  tag_q [CELL_LATENCY];
  logic [2:0]  tag_in, tag_out;

  logic        is_hi, accept, cap, last_cap;
  logic [5:0]  shamt;

  // Ops 01 and 10 take the high-word path; 00 and 11 take the low-word path.
  assign is_hi    = op_q[0] ^ op_q[1];
  assign accept   = req_valid && req_ready;
  assign tag_out  = tag_q[CELL_LATENCY-1];
  assign cap      = tag_out[2];
  assign last_cap = cap && (!is_hi || tag_out[1:0] == 2'd3);

  // LL -> 0, LH/HL -> 16, HH -> 32
  always_comb begin
    shamt = 6'd0;
    case (tag_out[1:0])
      2'd1, 2'd2: shamt = 6'd16;
      2'd3:       shamt = 6'd32;
      default:    shamt = 6'd0;
    endcase
  end

  assign acc_d = cap ? acc_q + ({32'd0, A_mul_cell_result} << shamt) : acc_q;

`ifdef NIOS_MUL_SIGNED_HI_EN
  // Signed high word from the unsigned product: subtract the operand that
  // the other operand's sign bit would have weighted by -2^32.
  always_comb begin
    hi_word = acc_d[63:32];
    if (op_q == 2'b10) begin
      hi_word = acc_d[63:32] - (a_q[31] ? b_q : 32'd0) - (b_q[31] ? a_q : 32'd0);
    end
  end
`else
  assign hi_word = acc_d[63:32];
`endif

  always_comb begin
    state_d = state_q;
    tag_in  = 3'b000;
    src1_d  = 32'd0;
    src2_d  = 32'd0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        tag_in = {1'b1, cnt_q};
        if (is_hi) begin
          // cnt[1] picks the A half, cnt[0] the B half: LL, LH, HL, HH
          src1_d = {16'd0, cnt_q[1] ? a_q[31:16] : a_q[15:0]};
          src2_d = {16'd0, cnt_q[0] ? b_q[31:16] : b_q[15:0]};
          if (cnt_q == 2'd3) state_d = DRAIN;
        end else begin
          src1_d  = a_q;
          src2_d  = b_q;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_cap) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
      cnt_q   <= 2'd0;
      acc_q   <= 64'd0;
      res_q   <= 32'd0;
      for (int i = 0; i < CELL_LATENCY; i++) tag_q[i] <= 3'b000;
    end else begin
      state_q <= state_d;
      for (int i = CELL_LATENCY - 1; i > 0; i--) tag_q[i] <= tag_q[i-1];
      tag_q[0] <= tag_in;
      if (accept) begin
        a_q   <= req_src1;
        b_q   <= req_src2;
        op_q  <= req_op;
        cnt_q <= 2'd0;
        acc_q <= 64'd0;
      end else begin
        acc_q <= acc_d;
        if (state_q == ISSUE) cnt_q <= cnt_q + 2'd1;
      end
      // Latch the answer on RESP entry so it holds steady under backpressure.
      if (state_q == DRAIN && last_cap) begin
        res_q <= is_hi ? hi_word : acc_d[31:0];
      end
    end
  end

  // Outputs are forced low while reset is asserted.
  assign req_ready  = !reset && state_q == IDLE;
  assign busy       = !reset && state_q != IDLE;
  assign rsp_valid  = !reset && state_q == RESP;
  assign rsp_result = rsp_valid ? res_q : 32'd0;
  assign A_mul_src1 = reset ? 32'd0 : src1_d;
  assign A_mul_src2 = reset ? 32'd0 : src2_d;

endmodule

// File: tb/tb_nios_mul_seq.sv
// tb/tb_nios_mul_seq.sv - testbench for nios_mul_seq (latency 1 and latency 3 instances)
module tb_nios_mul_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]       rv, rrdy, rspr, rspv, bsy;
  logic [1:0][1:0]  rop;
  logic [1:0][31:0] s1, s2, ms1, ms2, cres, rres;

  nios_mul_seq #(.CELL_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_ready(rrdy[0]), .req_op(rop[0]),
    .req_src1(s1[0]), .req_src2(s2[0]),
    .A_mul_src1(ms1[0]), .A_mul_src2(ms2[0]), .A_mul_cell_result(cres[0]),
    .rsp_valid(rspv[0]), .rsp_ready(rspr[0]), .rsp_result(rres[0]), .busy(bsy[0])
  );

  nios_mul_seq #(.CELL_LATENCY(3)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_ready(rrdy[1]), .req_op(rop[1]),
    .req_src1(s1[1]), .req_src2(s2[1]),
    .A_mul_src1(ms1[1]), .A_mul_src2(ms2[1]), .A_mul_cell_result(cres[1]),
    .rsp_valid(rspv[1]), .rsp_ready(rspr[1]), .rsp_result(rres[1]), .busy(bsy[1])
  );

  // Cell models: registered low-32 product, delayed 1 and 3 cycles.
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];
  always_ff @(posedge clk) begin
    pipe0    <= ms1[0] * ms2[0];
    pipe1[0] <= ms1[1] * ms2[1];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign cres[0] = pipe0;
  assign cres[1] = pipe1[2];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sbq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_src(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int c);
    logic [15:0] ah, bh;
    exp_src = 64'd0;
    if (op == 2'b01 || op == 2'b10) begin
      if (c >= 1 && c <= 4) begin
        ah = (c >= 3) ? a[31:16] : a[15:0];
        bh = (c == 2 || c == 4) ? b[31:16] : b[15:0];
        exp_src = {16'd0, ah, 16'd0, bh};
      end
    end else if (c == 1) begin
      exp_src = {a, b};
    end
  endfunction

  task automatic do_req(input int d, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string nm);
    int  lat;
    bit  seen;
    logic [31:0] e;
    lat  = (op == 2'b01 || op == 2'b10) ? (d ? 8 : 6) : (d ? 5 : 3);
    seen = 1'b0;
    @(negedge clk);
    chk({nm, " req_ready c0"}, 64'(rrdy[d]), 64'd1);
    rv[d] = 1'b1; rop[d] = op; s1[d] = a; s2[d] = b;
    sbq.push_back(exp);
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) rv[d] = 1'b0;
      chk({nm, " src"}, {ms1[d], ms2[d]}, exp_src(op, a, b, c));
      chk({nm, " busy"}, 64'(bsy[d]), 64'(!rspv[d] || 1'b1));
      if (rspv[d]) begin
        seen = 1'b1;
        chk({nm, " rsp cycle"}, 64'(c), 64'(lat));
        if (sbq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL %s: unexpected response %0h", nm, rres[d]);
        end else begin
          e = sbq.pop_front();
          chk({nm, " result"}, 64'(rres[d]), 64'(e));
        end
      end
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout waiting for rsp_valid", nm);
      sbq.delete();
    end
    @(negedge clk);
    chk({nm, " req_ready after"}, 64'(rrdy[d]), 64'd1);
    chk({nm, " rsp_valid after"}, 64'(rspv[d]), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

`ifdef NIOS_MUL_SIGNED_HI_EN
  localparam logic [31:0] EXP_SS1 = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_SS2 = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_SS1 = 32'h0000_0001;
  localparam logic [31:0] EXP_SS2 = 32'h0000_0002;
`endif

  vec_t vt [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'b00, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F};
    vt[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[2] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, EXP_SS1};
    vt[3] = '{2'b11, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    vt[4] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vt[5] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vt[6] = '{2'b10, 32'hFFFF_FFFE, 32'h0000_0003, EXP_SS2};
    vt[7] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vt[8] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vt[9] = '{2'b10, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};

    reset = 1'b1;
    rv = '0; rop = '0; s1 = '0; s2 = '0; rspr = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset req_ready", 64'(rrdy[d]), 64'd0);
      chk("reset rsp_valid", 64'(rspv[d]), 64'd0);
      chk("reset busy", 64'(bsy[d]), 64'd0);
      chk("reset result", 64'(rres[d]), 64'd0);
      chk("reset src", {ms1[d], ms2[d]}, 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready0", 64'(rrdy[0]), 64'd1);
    chk("post-reset req_ready1", 64'(rrdy[1]), 64'd1);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 10; i++)
        do_req(d, vt[i].op, vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d dut%0d", i, d));

    // Backpressure: MUL 7x6, rsp_ready low for five cycles, req_valid held high.
    @(negedge clk);
    chk("bp req_ready c0", 64'(rrdy[0]), 64'd1);
    rv[0] = 1'b1; rop[0] = 2'b00; s1[0] = 32'd7; s2[0] = 32'd6; rspr[0] = 1'b0;
    sbq.push_back(32'h0000_002A);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 8) begin
        chk("bp rsp_valid", 64'(rspv[0]), 64'd1);
        chk("bp rsp_result", 64'(rres[0]), 64'h2A);
      end
      if (c == 3) begin
        if (sbq.size() != 0) void'(sbq.pop_front());
      end
      if (c <= 8) chk("bp req_ready held", 64'(rrdy[0]), 64'd0);
      if (c == 8) begin
        rspr[0] = 1'b1;
        rv[0]   = 1'b0;
      end
      if (c == 9) begin
        chk("bp req_ready after", 64'(rrdy[0]), 64'd1);
        chk("bp rsp_valid after", 64'(rspv[0]), 64'd0);
      end
    end

    // Reset in cycle 2 of MULXUU: aborted, no response, then MUL 3x3.
    @(negedge clk);
    rv[0] = 1'b1; rop[0] = 2'b01; s1[0] = 32'hFFFF_FFFF; s2[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    rv[0] = 1'b0;
    chk("abort busy c1", 64'(bsy[0]), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort req_ready", 64'(rrdy[0]), 64'd0);
    chk("abort busy", 64'(bsy[0]), 64'd0);
    chk("abort rsp_valid", 64'(rspv[0]), 64'd0);
    chk("abort result", 64'(rres[0]), 64'd0);
    chk("abort src", {ms1[0], ms2[0]}, 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort no rsp", 64'(rspv[0]), 64'd0);
      chk("abort idle", 64'(bsy[0]), 64'd0);
    end
    do_req(0, 2'b00, 32'd3, 32'd3, 32'd9, "after abort");

    chk("scoreboard empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nios_mul_seq.md
Name: nios_mul_seq

Overview:
- Sequencer directly upstream of the Nios multiplier cell (32x32 -> low-32 product, registered, fixed latency).
- Accepts multiply requests over a valid/ready handshake and drives the cell's A_mul_src1/A_mul_src2 operands.
- Captures A_mul_cell_result and returns either the low 32-bit product, or the high 32 bits of the 64-bit product.
- For the high word it issues four 16x16 partial products to the cell (upper operand halves zeroed) and accumulates them.

Parameters:
- CELL_LATENCY, 1, cycles from operands applied on A_mul_src* to the matching A_mul_cell_result; legal 1..4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  2  00 MUL (low word), 01 MULXUU (high unsigned), 10 MULXSS (high signed), 11 reserved (executed as 00)
- req_src1  in  32  operand A
- req_src2  in  32  operand B
- A_mul_src1  out  32  to cell
- A_mul_src2  out  32  to cell
- A_mul_cell_result  in  32  from cell
- rsp_valid  out  1  result present
- rsp_ready  in  1  result consumed when rsp_valid & rsp_ready
- rsp_result  out  32  result word
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE. req_ready is 0 during the reset cycle and 1 in the first cycle after it.
- States:
  - IDLE: req_ready=1. On accept, register operands and op, then go to ISSUE.
  - ISSUE: drives one operand pair per cycle.
  - DRAIN: waits for outstanding results.
  - RESP: rsp_valid=1.
- Issue sequence (accept in cycle 0):
  - MUL: cycle 1 drives {src1, src2}.
  - MULXUU/MULXSS: cycles 1..4 drive LL={0,a[15:0]}x{0,b[15:0]}, LH={0,a[15:0]}x{0,b[31:16]}, HL={0,a[31:16]}x{0,b[15:0]}, HH={0,a[31:16]}x{0,b[31:16]}.
  - A_mul_src* are 0 in every cycle without an issue.
- Capture:
  - A 3-bit issue-tag shift register of depth CELL_LATENCY marks which cycle's A_mul_cell_result is valid and what it is.
  - Captures in cycle (issue cycle + CELL_LATENCY).
- Accumulator: 64-bit, cleared on accept. Adds LL<<0, LH<<16, HL<<16, HH<<32, zero-extended, modulo 2^64.
- RESP entry is the cycle after the last capture. For CELL_LATENCY=1:
  - MUL: rsp_valid in cycle 3.
  - High ops: rsp_valid in cycle 6.
- rsp_result:
  - MUL: captured low product.
  - High ops: acc[63:32], with signed correction when enabled (see Optional Feature).
- Backpressure:
  - rsp_valid and rsp_result stay stable until rsp_ready.
  - On the handshake cycle, move to IDLE; req_ready returns 1 the following cycle.
  - No new request is accepted while busy (no overlap).
- Reset in any state: aborts the operation, discards in-flight tags, no response emitted.
- Reserved op 11 behaves exactly as op 00.

Optional Feature:
- Macro NIOS_MUL_SIGNED_HI_EN.
- Defined: op 10 returns the signed high word, hi = acc[63:32] - (a[31] ? b : 0) - (b[31] ? a : 0), modulo 2^32. The correction is computed in RESP entry with no extra cycle.
- Undefined: op 10 executes as op 01 (unsigned high) and the correction logic is absent.

Test Plan:
- MUL, src1=0x0001_0003, src2=0x0000_0005, CELL_LATENCY=1, rsp_ready=1:
  - A_mul_src1/src2 = 0x0001_0003/0x0000_0005 in cycle 1.
  - rsp_valid in cycle 3 with rsp_result=0x0005_000F; req_ready=1 in cycle 4.
- MULXUU, 0xFFFF_FFFF x 0xFFFF_FFFF:
  - Four issues in cycles 1-4, each driving 0x0000_FFFF/0x0000_FFFF.
  - rsp_result=0xFFFF_FFFE in cycle 6.
- MULXSS, 0xFFFF_FFFF x 0x0000_0002:
  - With NIOS_MUL_SIGNED_HI_EN: rsp_result=0xFFFF_FFFF.
  - Without it: rsp_result=0x0000_0001.
- Backpressure, MUL 7x6 with rsp_ready=0 for 5 cycles:
  - rsp_valid=1 and rsp_result=0x0000_002A held stable throughout.
  - req_valid held high during this time sees req_ready=0.
  - Handshake, then req_ready=1 the next cycle.
- Reset asserted in cycle 2 of MULXUU:
  - All outputs 0 in the following cycle and no rsp_valid ever appears.
  - A subsequent MUL 3x3 returns 0x0000_0009.
- CELL_LATENCY=3, MULXUU 0x0001_0000 x 0x0001_0000 with a cell model delaying results 3 cycles:
  - rsp_result=0x0000_0001 in cycle 8.
